// File: rtl/l1_trig_pkg.sv
// Shared types and widths for the level-1 accept path: accepted-record layout and counter widths.
package l1_trig_pkg;
  localparam int EVT_ID_W = 16;
  localparam int CNT_W    = 16;
  localparam int REC_W    = 32;

  typedef struct packed {
    logic [EVT_ID_W-1:0] evt_id;
    logic [7:0]          energy;
    logic [7:0]          isol;
  } rec_t;
endpackage

// File: rtl/accept_fifo.sv
// First-word-fall-through record FIFO; head visible the cycle after the first push.
// Push is taken when not full or when a pop happens in the same cycle; head reads 0 while empty.
module accept_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  // When full, the slot being written is the one popped this same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end
endmodule

// File: rtl/l1_accept_ctrl.sv
// Level-1 accept: aligns event words to the trigger, applies prescale and deadtime, queues records.
// Accept-to-out_valid is 1 cycle into an empty queue; full queue without a pop drops and counts.
module l1_accept_ctrl
  import l1_trig_pkg::*;
#(
  parameter int PRESCALE   = 1,
  parameter int DEADTIME   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt_valid,
  input  logic [7:0]       energy,
  input  logic [7:0]       isol,
  input  logic             trigger,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REC_W-1:0] out_data,
  output logic             busy,
  output logic [CNT_W-1:0] n_accepted,
  output logic [CNT_W-1:0] n_vetoed,
  output logic [CNT_W-1:0] n_dropped
);
  logic                r_d_valid;
  logic [7:0]          r_d_energy;
  logic [7:0]          r_d_isol;
  logic [EVT_ID_W-1:0] r_evt_id;
  logic [7:0]          r_prescale;
  logic [7:0]          r_dead;
  logic [CNT_W-1:0]    r_n_acc;
  logic [CNT_W-1:0]    r_n_veto;
  logic [CNT_W-1:0]    r_n_drop;

  logic w_trig;
  logic w_dead_act;
  logic w_veto;
  logic w_ps_hit;
  logic w_ps_step;
  logic w_accept;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_full;
  logic w_empty;
  rec_t w_rec;

  assign w_trig     = r_d_valid & trigger;
  assign w_dead_act = (r_dead != 8'd0);
  assign w_veto     = w_trig & w_dead_act;
  assign w_ps_hit   = (r_prescale == 8'(PRESCALE - 1));
  assign w_ps_step  = w_trig & ~w_dead_act & ~w_ps_hit;
  assign w_accept   = w_trig & ~w_dead_act & w_ps_hit;
  assign w_pop      = ~w_empty & out_ready;
  assign w_push     = w_accept & (~w_full | w_pop);
  assign w_drop     = w_accept & w_full & ~w_pop;

  assign w_rec = '{evt_id: r_evt_id, energy: r_d_energy, isol: r_d_isol};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_valid  <= 1'b0;
      r_d_energy <= '0;
      r_d_isol   <= '0;
      r_evt_id   <= '0;
      r_prescale <= '0;
      r_dead     <= '0;
      r_n_acc    <= '0;
      r_n_veto   <= '0;
      r_n_drop   <= '0;
    end else begin
      r_d_valid  <= evt_valid;
      r_d_energy <= energy;
      r_d_isol   <= isol;
      if (r_d_valid) r_evt_id <= r_evt_id + 1'b1;
      // A dropped accept still consumes its prescale slot.
      if (w_accept)       r_prescale <= '0;
      else if (w_ps_step) r_prescale <= r_prescale + 1'b1;
      if (w_push)          r_dead <= 8'(DEADTIME);
      else if (w_dead_act) r_dead <= r_dead - 1'b1;
      if (w_push && r_n_acc != '1)  r_n_acc  <= r_n_acc + 1'b1;
      if (w_veto && r_n_veto != '1) r_n_veto <= r_n_veto + 1'b1;
      if (w_drop && r_n_drop != '1) r_n_drop <= r_n_drop + 1'b1;
    end
  end

  accept_fifo #(
    .WIDTH(REC_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_push_dat(w_rec),
    .i_pop     (w_pop),
    .o_head_dat(out_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign out_valid  = ~w_empty;
  assign busy       = w_dead_act;
  assign n_accepted = r_n_acc;
  assign n_vetoed   = r_n_veto;
  assign n_dropped  = r_n_drop;
endmodule

// File: tb/tb_l1_accept_ctrl.sv
// Directed bench: three instances (defaults, prescale 3 / no deadtime, no deadtime) share stimulus.
module tb_l1_accept_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       evt_valid = 1'b0;
  logic [7:0] energy = '0;
  logic [7:0] isol = '0;
  logic       trigger = 1'b0;
  logic       out_ready = 1'b0;

  logic        v   [3];
  logic [31:0] d   [3];
  logic        b   [3];
  logic [15:0] na  [3];
  logic [15:0] nv  [3];
  logic [15:0] nd  [3];

  logic [31:0] cap0 [$];
  logic [31:0] cap1 [$];
  logic [31:0] cap2 [$];

  int   checks = 0;
  int   errors = 0;
  logic pend_trig = 1'b0;

  always #5 clk = ~clk;

  l1_accept_ctrl u_def (
    .clk(clk), .rst(rst), .evt_valid(evt_valid), .energy(energy), .isol(isol),
    .trigger(trigger), .out_valid(v[0]), .out_ready(out_ready), .out_data(d[0]),
    .busy(b[0]), .n_accepted(na[0]), .n_vetoed(nv[0]), .n_dropped(nd[0]));

  l1_accept_ctrl #(.PRESCALE(3), .DEADTIME(0)) u_ps (
    .clk(clk), .rst(rst), .evt_valid(evt_valid), .energy(energy), .isol(isol),
    .trigger(trigger), .out_valid(v[1]), .out_ready(out_ready), .out_data(d[1]),
    .busy(b[1]), .n_accepted(na[1]), .n_vetoed(nv[1]), .n_dropped(nd[1]));

  l1_accept_ctrl #(.PRESCALE(1), .DEADTIME(0)) u_ov (
    .clk(clk), .rst(rst), .evt_valid(evt_valid), .energy(energy), .isol(isol),
    .trigger(trigger), .out_valid(v[2]), .out_ready(out_ready), .out_data(d[2]),
    .busy(b[2]), .n_accepted(na[2]), .n_vetoed(nv[2]), .n_dropped(nd[2]));

  always @(posedge clk) begin
    if (!rst && v[0] && out_ready) cap0.push_back(d[0]);
    if (!rst && v[1] && out_ready) cap1.push_back(d[1]);
    if (!rst && v[2] && out_ready) cap2.push_back(d[2]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The trigger for an event is presented one cycle after its evt_valid.
  task automatic drive_cycle(input logic vld, input logic [7:0] e, input logic [7:0] is,
                             input logic t);
    evt_valid = vld;
    energy    = e;
    isol      = is;
    trigger   = pend_trig;
    pend_trig = vld & t;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    evt_valid = 1'b0;
    trigger   = 1'b0;
    pend_trig = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    cap0.delete();
    cap1.delete();
    cap2.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({v[i], b[i], na[i], nv[i], nd[i], d[i]} !== 82'd0) begin
        errors++;
        $display("FAIL reset dut%0d: valid=%0b busy=%0b acc=%0d veto=%0d drop=%0d data=%h, want all 0",
                 i, v[i], b[i], na[i], nv[i], nd[i], d[i]);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    evt_valid = 1'b1; energy = 8'h40; isol = 8'h10;
    tick();
    evt_valid = 1'b0; energy = 8'h00; isol = 8'h00; trigger = 1'b1;
    checks++;
    if (v[0] !== 1'b0) begin
      errors++; $display("FAIL single_early_valid: got %0b want 0", v[0]);
    end
    tick();
    trigger = 1'b0;
    checks++;
    if (v[0] !== 1'b1 || d[0] !== 32'h0000_4010) begin
      errors++; $display("FAIL single_record: valid=%0b data=%h want 1 00004010", v[0], d[0]);
    end
    checks++;
    if (na[0] !== 16'd1) begin
      errors++; $display("FAIL single_n_accepted: got %0d want 1", na[0]);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (b[0] !== (c < 3)) begin
        errors++; $display("FAIL single_busy_c%0d: got %0b want %0b", c, b[0], (c < 3));
      end
      tick();
    end
    checks++;
    if (v[0] !== 1'b0 || cap0.size() != 1) begin
      errors++; $display("FAIL single_drained: valid=%0b pops=%0d want 0 1", v[0], cap0.size());
    end
  endtask

  task automatic test_deadtime();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'(i + 1), 8'h01, 1'b1);
    idle(8);
    checks++;
    if (nv[0] !== 16'd3 || na[0] !== 16'd2) begin
      errors++; $display("FAIL deadtime_counts: veto=%0d acc=%0d want 3 2", nv[0], na[0]);
    end
    checks++;
    if (cap0.size() != 2) begin
      errors++; $display("FAIL deadtime_pops: got %0d want 2", cap0.size());
    end else begin
      checks++;
      if (cap0[0] !== 32'h0000_0101 || cap0[1] !== 32'h0004_0501) begin
        errors++; $display("FAIL deadtime_records: got %h %h want 00000101 00040501",
                           cap0[0], cap0[1]);
      end
    end
  endtask

  task automatic test_prescale();
    logic [31:0] exp_rec [3];
    exp_rec[0] = 32'h0002_0322;
    exp_rec[1] = 32'h0005_0622;
    exp_rec[2] = 32'h0008_0922;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) drive_cycle(1'b1, 8'(i + 1), 8'h22, 1'b1);
    idle(4);
    checks++;
    if (na[1] !== 16'd3 || nv[1] !== 16'd0) begin
      errors++; $display("FAIL prescale_counts: acc=%0d veto=%0d want 3 0", na[1], nv[1]);
    end
    checks++;
    if (cap1.size() != 3) begin
      errors++; $display("FAIL prescale_pops: got %0d want 3", cap1.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (cap1[k] !== exp_rec[k]) begin
          errors++; $display("FAIL prescale_rec%0d: got %h want %h", k, cap1[k], exp_rec[k]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int waited;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 8'(8'h50 + i), 8'h0A, 1'b1);
    idle(3);
    checks++;
    if (na[2] !== 16'd4 || nd[2] !== 16'd2) begin
      errors++; $display("FAIL overflow_counts: acc=%0d drop=%0d want 4 2", na[2], nd[2]);
    end
    checks++;
    if (v[2] !== 1'b1 || d[2] !== 32'h0000_500A) begin
      errors++; $display("FAIL overflow_head_hold: valid=%0b data=%h want 1 0000500a", v[2], d[2]);
    end
    out_ready = 1'b1;
    waited = 0;
    while (cap2.size() < 4 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (cap2.size() != 4) begin
      errors++; $display("FAIL overflow_drain: got %0d pops want 4 within 20 cycles", cap2.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (cap2[k][31:16] !== 16'(k) || cap2[k][15:8] !== 8'(8'h50 + k)) begin
          errors++; $display("FAIL overflow_order%0d: got %h want id %0d energy %h",
                             k, cap2[k], k, 8'h50 + k);
        end
      end
    end
    tick();
    checks++;
    if (v[2] !== 1'b0) begin
      errors++; $display("FAIL overflow_empty: got %0b want 0", v[2]);
    end
  endtask

  task automatic test_full_pushpop_reset();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'(8'h60 + i), 8'h0B, 1'b1);
    checks++;
    if (na[2] !== 16'd4 || nd[2] !== 16'd0) begin
      errors++; $display("FAIL full_fill: acc=%0d drop=%0d want 4 0", na[2], nd[2]);
    end
    out_ready = 1'b1;
    drive_cycle(1'b0, 8'h00, 8'h00, 1'b0);
    out_ready = 1'b0;
    idle(2);
    checks++;
    if (na[2] !== 16'd5 || nd[2] !== 16'd0) begin
      errors++; $display("FAIL full_pushpop_counts: acc=%0d drop=%0d want 5 0", na[2], nd[2]);
    end
    checks++;
    if (cap2.size() != 1 || v[2] !== 1'b1 || d[2][31:16] !== 16'd1) begin
      errors++; $display("FAIL full_pushpop_head: pops=%0d valid=%0b head=%h want 1 1 id 1",
                         cap2.size(), v[2], d[2]);
    end
    do_reset();
    checks++;
    if ({v[2], b[2], na[2], nv[2], nd[2], d[2]} !== 82'd0) begin
      errors++; $display("FAIL midreset_state: valid=%0b acc=%0d veto=%0d drop=%0d data=%h want 0",
                         v[2], na[2], nv[2], nd[2], d[2]);
    end
    idle(3);
    checks++;
    if (v[2] !== 1'b0 || cap2.size() != 0) begin
      errors++; $display("FAIL midreset_quiet: valid=%0b pops=%0d want 0 0", v[2], cap2.size());
    end
    drive_cycle(1'b1, 8'h77, 8'h0C, 1'b1);
    drive_cycle(1'b0, 8'h00, 8'h00, 1'b0);
    checks++;
    if (v[2] !== 1'b1 || d[2] !== 32'h0000_770C) begin
      errors++; $display("FAIL midreset_first_id: valid=%0b data=%h want 1 0000770c", v[2], d[2]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_deadtime();
    test_prescale();
    test_overflow();
    test_full_pushpop_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/l1_accept_ctrl.md
# l1_accept_ctrl

Level-1 accept controller placed directly downstream of the nano trigger. It takes the per-event trigger decision and the calorimeter and muon words that produced it, then applies prescaling and a fixed deadtime. Accepted event records are buffered in a small FIFO and released to the readout over a valid/ready handshake. Saturating status counters record accepts, deadtime vetoes and FIFO-overflow drops.

## Interface
Parameters:
- `PRESCALE`, default 1: accept one of every PRESCALE triggered, non-vetoed events. Legal range 1..255; 1 means accept all.
- `DEADTIME`, default 3: number of decision cycles vetoed after each accept. Legal range 0..255.
- `FIFO_DEPTH`, default 4: number of accepted records buffered. Must be a power of two, at least 2.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `evt_valid`, in, 1: `energy` and `isol` hold a new event this cycle.
- `energy`, in, 8: signed calorimeter word, same value presented to the trigger.
- `isol`, in, 8: signed isolation word, same value presented to the trigger.
- `trigger`, in, 1: trigger decision. It arrives exactly 1 cycle after the event's `evt_valid`.
- `out_valid`, out, 1: `out_data` holds an accepted record.
- `out_ready`, in, 1: readout consumes the record when both `out_valid` and `out_ready` are high.
- `out_data`, out, 32: the record, packed as {evt_id[15:0], energy[7:0], isol[7:0]}.
- `busy`, out, 1: deadtime is active (dead counter is nonzero).
- `n_accepted`, out, 16: saturating count of records pushed into the FIFO.
- `n_vetoed`, out, 16: saturating count of triggered events lost to deadtime.
- `n_dropped`, out, 16: saturating count of accepted events lost because the FIFO was full.

## Operation
- **Alignment stage.** `evt_valid`, `energy` and `isol` are registered once, giving `d_valid`, `d_energy` and `d_isol`. The decision cycle is any cycle with `d_valid` = 1, and `trigger` is sampled in that same cycle.
- **Event numbering.** `evt_id` is a 16-bit counter. It tags the current decision, then increments on every decision cycle whether or not the event is triggered. It wraps from 0xFFFF to 0.
- **Decision.** The following priority order applies in each decision cycle:
  1. `trigger` = 0: no action.
  2. Dead counter is nonzero: veto the event and increment `n_vetoed`. The prescale counter is unchanged.
  3. Prescale counter is not equal to PRESCALE−1: increment the prescale counter and do not accept.
  4. Otherwise, clear the prescale counter and accept the event.
- **Accept.**
  - If the FIFO is not full, or a pop happens in the same cycle: push {evt_id, d_energy, d_isol}, load the dead counter with DEADTIME, and increment `n_accepted`.
  - If the FIFO is full and no pop happens: drop the event, increment `n_dropped`, and leave the dead counter unchanged.
- **Dead counter.** Decrements by 1 in every cycle that it is nonzero and no load occurs. A load takes priority over the decrement.
- **FIFO.** First-word-fall-through. `out_valid` equals "not empty" and `out_data` is the head entry. A simultaneous push and pop is legal at any fill level, including full and empty.
- **Status counters.** Each counter saturates at 0xFFFF and never wraps.
- **Reset.** Clears the FIFO pointers, `evt_id`, the prescale counter, the dead counter, all status counters and the alignment stage. After reset `out_valid` = 0, `busy` = 0, all counters read 0 and `out_data` = 0.
- **Reset mid-operation.** Queued records are discarded. Nothing is emitted after reset until a new accept occurs.

## Timing
- **Accept latency.** With `evt_valid` at cycle N, `trigger` is sampled at cycle N+1. The push happens at the end of cycle N+1, and `out_valid` is high in cycle N+2 when the FIFO was empty.
- **Veto window.** After an accept in decision cycle D, a triggered event whose decision falls in cycles D+1 … D+DEADTIME is vetoed. `busy` is high in exactly those cycles.
- **Handshake rules.**
  - Once asserted, `out_valid` and `out_data` hold until accepted.
  - `out_valid` never depends combinationally on `out_ready`.
- **Throughput.** One decision per cycle and one pop per cycle.

## Structure
- **Shared package `l1_trig_pkg`.** Holds the record typedef {evt_id, energy, isol} and its width constant (32), the `EVT_ID_W` constant (16) and the `CNT_W` constant (16).
- **Sub-module `accept_fifo`.** Parameterised synchronous FWFT FIFO (width, depth). It exposes push, pop, full and empty, and supports simultaneous push and pop when full. The top level contains the alignment, decision, prescale and deadtime logic and the counters.

## Test plan
- **Single accept.** Defaults, one event (0x40, 0x10) with `trigger` = 1 and `out_ready` held at 1 → `out_valid` high in cycle N+2 with `out_data` = 0x0000_4010. Afterwards `n_accepted` = 1 and `busy` is high for 3 cycles.
- **Deadtime.** Defaults, triggered events on 5 consecutive cycles → events 0 and 4 are accepted and events 1–3 are vetoed, giving `n_vetoed` = 3 and `n_accepted` = 2.
- **Prescale.** PRESCALE = 3, DEADTIME = 0, 9 triggered events → only `evt_id` 2, 5 and 8 are emitted, and `n_accepted` = 3.
- **Overflow.** DEADTIME = 0, `out_ready` = 0, 6 triggered events → 4 records are queued and `n_dropped` = 2. Raising `out_ready` drains `evt_id` 0–3 in order.
- **Full push+pop and reset.** FIFO full and `out_ready` = 1, with a triggered event in the same cycle → the push succeeds and no drop is counted. Asserting `rst` afterwards → `out_valid` = 0, all counters read 0, and the next accepted event has `evt_id` 0.
